// File: rtl/hamming_encoder_stream.sv
// Streaming (12,8) Hamming encoder: a 2-entry codeword FIFO with valid/ready handshakes,
// a one-shot single-bit fault injector and a saturating output-transfer counter.
module hamming_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_code,
  input  logic             inj_arm,
  input  logic [3:0]       inj_pos,
  output logic             inj_busy,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {IDLE, ARMED} inj_state_t;

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d, p};
  endfunction

  inj_state_t  inj_state;
  logic [3:0]  pos_q;
  logic [1:0]  occ, occ_nxt;
  logic [11:0] tail_q;
  logic [11:0] flip_mask, wcode;
  logic        push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign flip_mask = (inj_state == ARMED) ? (12'd1 << pos_q) : 12'd0;
  assign wcode     = encode(in_data) ^ flip_mask;
  assign inj_busy  = (inj_state == ARMED);

  // push only happens below occupancy 2 and pop only above 0, so this never wraps
  always_comb begin
    occ_nxt = occ + {1'b0, push} - {1'b0, pop};
  end

  // out_code is the head register; tail_q only holds the second entry
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      occ       <= 2'd0;
      out_code  <= 12'h000;
      tail_q    <= 12'h000;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) out_code <= wcode;
        end
        2'd1: begin
          if (push && pop) out_code <= wcode;
          else if (push)   tail_q   <= wcode;
        end
        default: begin
          if (pop) out_code <= tail_q;
        end
      endcase
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != 2'd0);
      in_ready  <= (occ_nxt < 2'd2);
    end
  end

  // arming is only honoured from IDLE, so a coincident push in IDLE stays clean
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      inj_state <= IDLE;
      pos_q     <= 4'd0;
    end else begin
      case (inj_state)
        IDLE: begin
          if (inj_arm && (inj_pos <= 4'd11)) begin
            inj_state <= ARMED;
            pos_q     <= inj_pos;
          end
        end
        default: begin
          if (push) inj_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                       word_cnt <= '0;
    else if (pop && (~word_cnt != '0)) word_cnt <= word_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Directed bench for hamming_encoder_stream: encode vectors, back-pressure, injection,
// full single-flip loopback through a reference (12,8) decoder, reset and counter saturation.
module tb_hamming_encoder_stream;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, inj_arm;
  logic [7:0]  in_data;
  logic [3:0]  inj_pos;
  logic        in_ready, out_valid, inj_busy;
  logic [11:0] out_code;
  logic [15:0] word_cnt;

  logic        in_ready4, out_valid4, inj_busy4;
  logic [11:0] out_code4;
  logic [3:0]  word_cnt4;

  int checks   = 0;
  int failures = 0;
  int words    = 0;

  always #5 sys_clk = ~sys_clk;

  hamming_encoder_stream #(.CNT_W(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_busy(inj_busy), .word_cnt(word_cnt)
  );

  hamming_encoder_stream #(.CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_code(out_code4),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_busy(inj_busy4), .word_cnt(word_cnt4)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference decoder: syndrome value is the classic Hamming position of the flipped bit
  function automatic logic [7:0] decode(input logic [11:0] c);
    logic [3:0] s;
    logic [11:0] fixed;
    int idx;
    s[0] = c[0] ^ c[4] ^ c[5] ^ c[7] ^ c[8] ^ c[10];
    s[1] = c[1] ^ c[4] ^ c[6] ^ c[7] ^ c[9] ^ c[10];
    s[2] = c[2] ^ c[5] ^ c[6] ^ c[7] ^ c[11];
    s[3] = c[3] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
    case (s)
      4'd1: idx = 0;   4'd2: idx = 1;   4'd4: idx = 2;   4'd8: idx = 3;
      4'd3: idx = 4;   4'd5: idx = 5;   4'd6: idx = 6;   4'd7: idx = 7;
      4'd9: idx = 8;   4'd10: idx = 9;  4'd11: idx = 10; 4'd12: idx = 11;
      default: idx = -1;
    endcase
    fixed = c;
    if (idx >= 0) fixed[idx] = ~fixed[idx];
    return fixed[11:4];
  endfunction

  logic [7:0]  vec_d [4] = '{8'h00, 8'hFF, 8'hA5, 8'h01};
  logic [11:0] vec_c [4] = '{12'h000, 12'hFF3, 12'hA53, 12'h013};
  logic [11:0] clean;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_arm = 1'b0;
    in_data = 8'h00; inj_pos = 4'd0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code",  out_code, 12'h000);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_inj_busy",  inj_busy, 0);
    chk("rst_word_cnt",  word_cnt, 0);

    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);
    chk("out_valid_after_rst", out_valid, 0);

    // encode vectors, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_d[i];
      tick();
      chk("enc_valid", out_valid, 1);
      chk("enc_code", out_code, vec_c[i]);
      in_valid = 1'b0;
      tick();
      chk("enc_drain", out_valid, 0);
    end
    chk("cnt_after_enc", word_cnt, 4);

    // back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    chk("bp_ready_1", in_ready, 1);
    in_data = 8'h22; tick();
    chk("bp_full", in_ready, 0);
    chk("bp_head", out_code, 12'h11A);
    in_data = 8'h33; tick(); tick();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_head", out_code, 12'h11A);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_code", out_code, 12'h22F);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("cnt_after_bp", word_cnt, 6);

    // push and pop together at occupancy 1
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5; tick();
    out_ready = 1'b1; in_data = 8'h01; tick();
    chk("pp_valid", out_valid, 1);
    chk("pp_code", out_code, 12'h013);
    chk("pp_ready", in_ready, 1);
    in_valid = 1'b0; tick();
    chk("pp_empty", out_valid, 0);
    chk("cnt_after_pp", word_cnt, 8);

    // injection on bit 4, only the first word corrupted
    out_ready = 1'b0;
    inj_arm = 1'b1; inj_pos = 4'd4; tick();
    inj_arm = 1'b0;
    chk("inj_busy_armed", inj_busy, 1);
    in_valid = 1'b1; in_data = 8'hA5; tick();
    chk("inj_busy_cleared", inj_busy, 0);
    chk("inj_code_1", out_code, 12'hA43);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("inj_code_2", out_code, 12'hA53);
    tick();
    chk("cnt_after_inj", word_cnt, 10);

    // arm coincident with a push while IDLE: that word stays clean, the next is hit
    inj_arm = 1'b1; inj_pos = 4'd0; in_valid = 1'b1; in_data = 8'h00; tick();
    inj_arm = 1'b0;
    chk("coinc_code", out_code, 12'h000);
    chk("coinc_busy", inj_busy, 1);
    tick();
    chk("coinc_next_code", out_code, 12'h001);
    chk("coinc_busy_clr", inj_busy, 0);
    in_valid = 1'b0; tick();

    // out-of-range position is ignored
    inj_arm = 1'b1; inj_pos = 4'd12; tick();
    inj_arm = 1'b0;
    chk("bad_pos_busy", inj_busy, 0);
    in_valid = 1'b1; in_data = 8'hFF; tick();
    chk("bad_pos_code", out_code, 12'hFF3);
    in_valid = 1'b0; tick();

    // re-arm while ARMED is ignored: bit 5 flips, not bit 6
    inj_arm = 1'b1; inj_pos = 4'd5; tick();
    inj_pos = 4'd6; tick();
    inj_arm = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; tick();
    chk("rearm_code", out_code, 12'h020);
    in_valid = 1'b0; tick();
    chk("cnt_before_loop", word_cnt, 14);
    words = 14;

    // loopback: every byte, clean and with each single-bit flip
    out_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      for (int f = -1; f < 12; f++) begin
        if (f >= 0) begin
          inj_arm = 1'b1; inj_pos = 4'(f); tick();
          inj_arm = 1'b0;
        end
        in_valid = 1'b1; in_data = 8'(b); tick();
        in_valid = 1'b0;
        if (f < 0) begin
          clean = out_code;
          chk("loop_data_field", {20'd0, clean[11:4]}, b);
          chk("loop_clean_syndrome", {24'd0, decode(clean)}, b);
        end else begin
          chk("loop_flip_dist", 32'($countones(out_code ^ clean)), 1);
          chk("loop_decode", {24'd0, decode(out_code)}, b);
        end
        words++;
        tick();
      end
    end
    chk("cnt_after_loop", word_cnt, words);
    chk("cnt4_saturated", word_cnt4, 4'hF);

    // reset with FIFO full and an injection armed
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_data = 8'h66; tick();
    in_valid = 1'b0;
    inj_arm = 1'b1; inj_pos = 4'd3; tick();
    inj_arm = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_armed", inj_busy, 1);
    rst = 1'b1; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_code", out_code, 12'h000);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_inj_busy", inj_busy, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_word_cnt4", word_cnt4, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1; tick();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_no_stale", out_valid, 0);
    tick();
    chk("post_rst_no_stale_2", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h01; tick();
    chk("post_rst_clean_code", out_code, 12'h013);
    in_valid = 1'b0; tick();
    chk("post_rst_cnt", word_cnt, 1);

    // drive the 4-bit counter past 15 again from zero
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1; in_data = 8'(i); tick();
      in_valid = 1'b0; tick();
    end
    chk("cnt16_20", word_cnt, 20);
    chk("cnt4_hold_F", word_cnt4, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
